hls_ctrl_sequencer: RTL and testbench

Converts the level-style GPIO control bits for one HLS kernel (start, complete) into a correct `ap_ctrl_chain` handshake, and returns the finish/idle status bits to the GPIO read word. It sits directly downstream of the GPIO connection block: one instance per kernel (forward, backward, param loader, grad extractor), between that block's per-kernel start/complete/finish/idle wires and the kernel's `ap_*` control ports.

---
 rtl/hls_ctrl_sequencer_if.sv | 24 ++
 rtl/hls_ctrl_sequencer.sv | 107 ++++++++++
 tb/tb_hls_ctrl_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hls_ctrl_sequencer_if.sv
// ap_ctrl_chain handshake bundle between a sequencer (master) and one HLS kernel (slave).
interface hls_ctrl_sequencer_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_idle;
  logic ap_continue;

  modport master (
    output ap_start,
    output ap_continue,
    input  ap_ready,
    input  ap_done,
    input  ap_idle
  );

  modport slave (
    input  ap_start,
    input  ap_continue,
    output ap_ready,
    output ap_done,
    output ap_idle
  );
endinterface

// File: rtl/hls_ctrl_sequencer.sv
// Turns GPIO start/complete levels into an ap_ctrl_chain handshake for one kernel.
// Optional run-cycle counter enabled by defining HLS_CTRL_CYCLE_CNT_EN.
module hls_ctrl_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             complete,
  output logic             finish,
  output logic             idle,
  output logic             spurious_done,
  output logic [CNT_W-1:0] run_cycles,
  hls_ctrl_sequencer_if.master ap
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t state;
  logic   start_q;
  logic   complete_q;
  logic   start_edge;
  logic   complete_edge;

  assign start_edge    = start & ~start_q;
  assign complete_edge = complete & ~complete_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      start_q        <= 1'b0;
      complete_q     <= 1'b0;
      ap.ap_start    <= 1'b0;
      ap.ap_continue <= 1'b0;
      finish         <= 1'b0;
      idle           <= 1'b0;
      spurious_done  <= 1'b0;
    end else begin
      start_q        <= start;
      complete_q     <= complete;
      ap.ap_continue <= 1'b0;
      idle           <= (state == ST_IDLE) && ap.ap_idle;
      case (state)
        ST_IDLE: begin
          if (ap.ap_done) spurious_done <= 1'b1;
          if (start_edge) begin
            state       <= ST_ISSUE;
            ap.ap_start <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // A kernel may raise done without ever raising ready; either ends the start phase.
          if (ap.ap_ready || ap.ap_done) begin
            ap.ap_start <= 1'b0;
            if (ap.ap_done) begin
              state  <= ST_DONE;
              finish <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (ap.ap_done) begin
            state  <= ST_DONE;
            finish <= 1'b1;
          end
        end
        ST_DONE: begin
          if (complete_edge) begin
            state          <= ST_IDLE;
            finish         <= 1'b0;
            ap.ap_continue <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef HLS_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             running;

  assign running = (state == ST_ISSUE) || (state == ST_WAIT);
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  // The latched value includes the cycle in which ap_done is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      run_cycles <= '0;
    end else begin
      if (state == ST_IDLE && start_edge) begin
        cnt <= '0;
      end else if (running) begin
        cnt <= cnt_inc;
        if (ap.ap_done) run_cycles <= cnt_inc;
      end
    end
  end
`else
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_hls_ctrl_sequencer.sv
// Self-checking bench for hls_ctrl_sequencer: directed and randomized kernel runs vs. a run-level model.
module tb_hls_ctrl_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SAT_I = (1 << CNT_W) - 1;
`ifdef HLS_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             complete;
  logic             finish;
  logic             idle;
  logic             spurious_done;
  logic [CNT_W-1:0] run_cycles;

  int errors = 0;
  int checks = 0;

  hls_ctrl_sequencer_if kif ();

  hls_ctrl_sequencer #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .complete      (complete),
    .finish        (finish),
    .idle          (idle),
    .spurious_done (spurious_done),
    .run_cycles    (run_cycles),
    .ap            (kif)
  );

  always #5 clk = ~clk;

  // Expected run_cycles: number of cycles from the first ap_start cycle to the ap_done sample, saturated.
  function automatic logic [CNT_W-1:0] exp_cycles(input int unsigned n);
    if (!CNT_EN) return '0;
    if (n >= SAT_I) return CNT_W'(SAT_I);
    return CNT_W'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready_at/done_at are 1-based indices of ap_start cycles at which the kernel raises ready/done.
  task automatic do_run(input int unsigned ready_at, input int unsigned done_at,
                        input bit toggle_start, input bit hold_complete, input string name);
    int unsigned width = 0;
    bit early_finish = 1'b0;
    start = 1'b1;
    if (hold_complete) complete = 1'b1;
    for (int unsigned k = 1; k <= done_at; k++) begin
      tick();
      if (ap_start_now()) width++;
      if (finish) early_finish = 1'b1;
      kif.ap_idle  = 1'b0;
      kif.ap_ready = (k == ready_at);
      kif.ap_done  = (k >= done_at);
      if (toggle_start && k > 1) start = k[0];
    end
    tick();
    kif.ap_ready = 1'b0;
    checks++;
    if (width !== ready_at)
      $display("FAIL %s ap_start_width: got %0d expected %0d", name, width, ready_at);
    if (width !== ready_at) errors++;
    checks++;
    if (early_finish !== 1'b0) begin
      $display("FAIL %s early_finish: got %0b expected 0", name, early_finish);
      errors++;
    end
    checks++;
    if (finish !== 1'b1 || kif.ap_start !== 1'b0 || idle !== 1'b0) begin
      $display("FAIL %s done_state: finish=%b ap_start=%b idle=%b expected 1 0 0",
               name, finish, kif.ap_start, idle);
      errors++;
    end
    checks++;
    if (run_cycles !== exp_cycles(done_at)) begin
      $display("FAIL %s run_cycles: got %0d expected %0d", name, run_cycles, exp_cycles(done_at));
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      if (toggle_start) start = ~start;
      tick();
      checks++;
      if (kif.ap_start !== 1'b0 || kif.ap_continue !== 1'b0 || finish !== 1'b1) begin
        $display("FAIL %s hold_done: ap_start=%b ap_continue=%b finish=%b expected 0 0 1",
                 name, kif.ap_start, kif.ap_continue, finish);
        errors++;
      end
    end
  endtask

  function automatic bit ap_start_now();
    return kif.ap_start === 1'b1;
  endfunction

  // Drop and re-raise complete; optionally raise start in the same cycle (that start edge must be lost).
  task automatic do_release(input bit with_start, input string name);
    complete = 1'b0;
    start    = 1'b0;
    tick();
    complete = 1'b1;
    if (with_start) start = 1'b1;
    tick();
    checks++;
    if (kif.ap_continue !== 1'b1 || finish !== 1'b0 || kif.ap_start !== 1'b0) begin
      $display("FAIL %s release: ap_continue=%b finish=%b ap_start=%b expected 1 0 0",
               name, kif.ap_continue, finish, kif.ap_start);
      errors++;
    end
    kif.ap_done = 1'b0;
    kif.ap_idle = 1'b1;
    tick();
    checks++;
    if (kif.ap_continue !== 1'b0 || idle !== 1'b1) begin
      $display("FAIL %s after_release: ap_continue=%b idle=%b expected 0 1",
               name, kif.ap_continue, idle);
      errors++;
    end
    tick();
    tick();
    checks++;
    if (kif.ap_start !== 1'b0 || idle !== 1'b1 || finish !== 1'b0) begin
      $display("FAIL %s settle_idle: ap_start=%b idle=%b finish=%b expected 0 1 0",
               name, kif.ap_start, idle, finish);
      errors++;
    end
    complete = 1'b0;
    start    = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (kif.ap_start !== 1'b0 || kif.ap_continue !== 1'b0 || finish !== 1'b0 || idle !== 1'b0 ||
        spurious_done !== 1'b0 || run_cycles !== '0) begin
      $display("FAIL %s zero_outputs: ap_start=%b ap_continue=%b finish=%b idle=%b spurious=%b run_cycles=%0d expected all 0",
               name, kif.ap_start, kif.ap_continue, finish, idle, spurious_done, run_cycles);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    complete = 1'b0;
    kif.ap_ready = 1'b0;
    kif.ap_done  = 1'b0;
    kif.ap_idle  = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (idle !== 1'b1 || kif.ap_start !== 1'b0) begin
      $display("FAIL reset idle_after_release: idle=%b ap_start=%b expected 1 0", idle, kif.ap_start);
      errors++;
    end
  endtask

  task automatic test_basic();
    do_run(3, 13, 1'b0, 1'b0, "basic");
    do_release(1'b0, "basic");
  endtask

  task automatic test_combinational();
    do_run(1, 1, 1'b0, 1'b0, "comb");
    do_release(1'b0, "comb");
  endtask

  task automatic test_ignored_edges();
    do_run(2, 6, 1'b1, 1'b0, "toggle_start");
    do_release(1'b1, "toggle_start");
    do_run(1, 4, 1'b0, 1'b1, "hold_complete");
    do_release(1'b0, "hold_complete");
  endtask

  task automatic test_saturation();
    do_run(1, 20, 1'b0, 1'b0, "saturate");
    do_release(1'b0, "saturate");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      int unsigned r = $urandom_range(1, 4);
      int unsigned d = r + $urandom_range(0, 20);
      bit ts = 1'($urandom_range(0, 1));
      bit hc = 1'($urandom_range(0, 1));
      do_run(r, d, ts, hc, "random");
      do_release(1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_spurious();
    checks++;
    if (spurious_done !== 1'b0) begin
      $display("FAIL spurious before: got %b expected 0", spurious_done);
      errors++;
    end
    kif.ap_done = 1'b1;
    tick();
    kif.ap_done = 1'b0;
    tick();
    tick();
    checks++;
    if (spurious_done !== 1'b1 || kif.ap_start !== 1'b0 || idle !== 1'b1 || finish !== 1'b0) begin
      $display("FAIL spurious set: spurious=%b ap_start=%b idle=%b finish=%b expected 1 0 1 0",
               spurious_done, kif.ap_start, idle, finish);
      errors++;
    end
    do_run(2, 5, 1'b0, 1'b0, "after_spurious");
    do_release(1'b0, "after_spurious");
    checks++;
    if (spurious_done !== 1'b1) begin
      $display("FAIL spurious sticky: got %b expected 1", spurious_done);
      errors++;
    end
  endtask

  task automatic test_reset_mid_wait();
    start = 1'b1;
    tick();
    kif.ap_idle  = 1'b0;
    kif.ap_ready = 1'b1;
    tick();
    kif.ap_ready = 1'b0;
    tick();
    checks++;
    if (kif.ap_start !== 1'b0 || finish !== 1'b0 || idle !== 1'b0) begin
      $display("FAIL midwait state: ap_start=%b finish=%b idle=%b expected 0 0 0",
               kif.ap_start, finish, idle);
      errors++;
    end
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midwait_async");
    start = 1'b0;
    kif.ap_idle = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (idle !== 1'b1 || kif.ap_start !== 1'b0 || finish !== 1'b0 || spurious_done !== 1'b0) begin
      $display("FAIL midwait recover: idle=%b ap_start=%b finish=%b spurious=%b expected 1 0 0 0",
               idle, kif.ap_start, finish, spurious_done);
      errors++;
    end
    do_run(2, 7, 1'b0, 1'b0, "post_reset");
    do_release(1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_combinational();
    test_ignored_edges();
    test_saturation();
    test_random();
    test_spurious();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
